// File: rtl/light_monitor_pkg.sv
// Shared definitions for the traffic-light monitor: lamp encodings, phase codes,
// fault codes, FSM state type, default dwell times and the phase successor function.
// Latency: n/a (package). Backpressure: n/a.
package light_monitor_pkg;

   // Lamp bus encodings (one-hot per lamp head)
   localparam logic [2:0] LAMP_RED = 3'b100;
   localparam logic [2:0] LAMP_AMB = 3'b010;
   localparam logic [2:0] LAMP_GRN = 3'b001;

   // Default required dwell, in clk cycles, of each phase
   localparam int DEF_DWELL_P1 = 8;
   localparam int DEF_DWELL_P2 = 3;
   localparam int DEF_DWELL_P3 = 6;
   localparam int DEF_DWELL_P4 = 3;
   localparam int DEF_DWELL_P5 = 4;
   localparam int DEF_DWELL_P6 = 3;

   typedef enum logic [2:0] {
      PH_ILLEGAL = 3'd0,
      PH_1       = 3'd1,
      PH_2       = 3'd2,
      PH_3       = 3'd3,
      PH_4       = 3'd4,
      PH_5       = 3'd5,
      PH_6       = 3'd6
   } phase_t;

   typedef enum logic [1:0] {
      FC_NONE    = 2'd0,
      FC_ILLEGAL = 2'd1,
      FC_BAD_SEQ = 2'd2,
      FC_DWELL   = 2'd3
   } fault_code_t;

   typedef enum logic [1:0] {
      ST_SYNC  = 2'd0,
      ST_TRACK = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   // All four observed lamp buses, M1 in the most significant bits
   typedef struct packed {
      logic [2:0] m1;
      logic [2:0] m2;
      logic [2:0] mt;
      logic [2:0] st;
   } lamps_t;

   // Only legal successor of a phase; an illegal phase has no successor.
   function automatic phase_t next_phase(input phase_t p);
      case (p)
         PH_1:    next_phase = PH_2;
         PH_2:    next_phase = PH_3;
         PH_3:    next_phase = PH_4;
         PH_4:    next_phase = PH_5;
         PH_5:    next_phase = PH_6;
         PH_6:    next_phase = PH_1;
         default: next_phase = PH_ILLEGAL;
      endcase
   endfunction

endpackage

// File: rtl/light_monitor_phase_decode.sv
// Combinational decode of the four lamp buses into a phase number (0 = illegal).
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: i_lamps - {M1,M2,MT,ST} lamp buses; o_phase - decoded phase 1..6 or 0.
module phase_decode
   import light_monitor_pkg::*;
(
   input  lamps_t i_lamps,
   output phase_t o_phase
);

   always_comb begin
      o_phase = PH_ILLEGAL;
      case (i_lamps)
         {LAMP_GRN, LAMP_GRN, LAMP_RED, LAMP_RED}: o_phase = PH_1;
         {LAMP_GRN, LAMP_AMB, LAMP_RED, LAMP_RED}: o_phase = PH_2;
         {LAMP_GRN, LAMP_RED, LAMP_GRN, LAMP_RED}: o_phase = PH_3;
         {LAMP_AMB, LAMP_RED, LAMP_AMB, LAMP_RED}: o_phase = PH_4;
         {LAMP_RED, LAMP_RED, LAMP_RED, LAMP_GRN}: o_phase = PH_5;
         {LAMP_RED, LAMP_RED, LAMP_RED, LAMP_AMB}: o_phase = PH_6;
         default:                                  o_phase = PH_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/light_monitor.sv
// Traffic-light sequence monitor: checks lamp patterns, phase order and phase dwell.
// Latency: inputs registered at edge N are judged at edge N+1 (fault/locked/cycle_done).
// Backpressure: none; observes every clk, a latched fault holds until clr_fault.
// Ports: clk, rst (async, active-low); light_M1/M2/MT/ST lamp buses; clr_fault;
//        phase (decode of registered sample), locked (TRACK), fault, fault_code,
//        cycle_done (pulse per completed P6->P1), cycle_cnt (wrapping count).
module light_monitor
   import light_monitor_pkg::*;
#(
   parameter int DWELL_P1 = DEF_DWELL_P1,
   parameter int DWELL_P2 = DEF_DWELL_P2,
   parameter int DWELL_P3 = DEF_DWELL_P3,
   parameter int DWELL_P4 = DEF_DWELL_P4,
   parameter int DWELL_P5 = DEF_DWELL_P5,
   parameter int DWELL_P6 = DEF_DWELL_P6
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] light_M1,
   input  logic [2:0] light_M2,
   input  logic [2:0] light_MT,
   input  logic [2:0] light_ST,
   input  logic       clr_fault,
   output logic [2:0] phase,
   output logic       locked,
   output logic       fault,
   output logic [1:0] fault_code,
   output logic       cycle_done,
   output logic [7:0] cycle_cnt
);

   lamps_t      w_in;
   lamps_t      r_cur;
   lamps_t      r_prev;
   logic        r_cur_vld;
   logic        r_prev_vld;
   phase_t      w_cur_ph;
   phase_t      w_prev_ph;
   logic        w_change;
   logic        w_succ;
   logic        w_illegal;
   logic [3:0]  w_dwell_req;
   fault_code_t w_sync_code;
   fault_code_t w_track_code;

   state_t      r_state;
   logic [3:0]  r_dwell;
   logic        r_locked;
   logic        r_fault;
   fault_code_t r_fault_code;
   logic        r_cycle_done;
   logic [7:0]  r_cycle_cnt;

   function automatic logic [3:0] dwell_of(input phase_t p);
      case (p)
         PH_1:    dwell_of = 4'(DWELL_P1);
         PH_2:    dwell_of = 4'(DWELL_P2);
         PH_3:    dwell_of = 4'(DWELL_P3);
         PH_4:    dwell_of = 4'(DWELL_P4);
         PH_5:    dwell_of = 4'(DWELL_P5);
         PH_6:    dwell_of = 4'(DWELL_P6);
         default: dwell_of = 4'd0;
      endcase
   endfunction

   assign w_in = {light_M1, light_M2, light_MT, light_ST};

   // Input stage. The valid flags keep the cleared reset value out of the
   // illegal-pattern and change checks until real samples have arrived.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cur      <= '0;
         r_prev     <= '0;
         r_cur_vld  <= 1'b0;
         r_prev_vld <= 1'b0;
      end else begin
         r_cur      <= w_in;
         r_prev     <= r_cur;
         r_cur_vld  <= 1'b1;
         r_prev_vld <= r_cur_vld;
      end
   end

   phase_decode u_dec_cur  (.i_lamps(r_cur),  .o_phase(w_cur_ph));
   phase_decode u_dec_prev (.i_lamps(r_prev), .o_phase(w_prev_ph));

   assign w_change    = r_prev_vld && (w_cur_ph != w_prev_ph);
   assign w_succ      = (w_cur_ph == next_phase(w_prev_ph));
   assign w_illegal   = r_cur_vld && (w_cur_ph == PH_ILLEGAL);
   // Dwell of the departing phase; with no change prev and cur are the same phase.
   assign w_dwell_req = dwell_of(w_prev_ph);

   // Fault classification, highest priority first. In SYNC (and when clearing)
   // a change away from an illegal prev sample is a resync, not a bad sequence.
   always_comb begin
      w_sync_code = FC_NONE;
      if (w_illegal)
         w_sync_code = FC_ILLEGAL;
      else if (w_change && (w_prev_ph != PH_ILLEGAL) && !w_succ)
         w_sync_code = FC_BAD_SEQ;

      w_track_code = FC_NONE;
      if (w_illegal)
         w_track_code = FC_ILLEGAL;
      else if (w_change && !w_succ)
         w_track_code = FC_BAD_SEQ;
      else if (w_change ? (r_dwell != w_dwell_req) : (r_dwell == w_dwell_req))
         // r_dwell == req with no change means this sample is one too many
         w_track_code = FC_DWELL;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_SYNC;
         r_dwell      <= 4'd0;
         r_locked     <= 1'b0;
         r_fault      <= 1'b0;
         r_fault_code <= FC_NONE;
         r_cycle_done <= 1'b0;
         r_cycle_cnt  <= 8'd0;
      end else begin
         r_cycle_done <= 1'b0;
         case (r_state)
            ST_SYNC: begin
               if (w_sync_code != FC_NONE) begin
                  r_state      <= ST_FAULT;
                  r_fault      <= 1'b1;
                  r_fault_code <= w_sync_code;
                  r_locked     <= 1'b0;
               end else if (w_change && w_succ) begin
                  r_state  <= ST_TRACK;
                  r_locked <= 1'b1;
                  r_dwell  <= 4'd1;
               end
            end
            ST_TRACK: begin
               if (w_track_code != FC_NONE) begin
                  r_state      <= ST_FAULT;
                  r_fault      <= 1'b1;
                  r_fault_code <= w_track_code;
                  r_locked     <= 1'b0;
               end else if (w_change) begin
                  r_dwell <= 4'd1;
                  if (w_prev_ph == PH_6) begin
                     r_cycle_done <= 1'b1;
                     r_cycle_cnt  <= r_cycle_cnt + 8'd1;
                  end
               end else if (r_dwell != 4'hF) begin
                  r_dwell <= r_dwell + 4'd1;
               end
            end
            ST_FAULT: begin
               if (clr_fault) begin
                  // A fault seen while clearing wins over the clear
                  if (w_sync_code != FC_NONE) begin
                     r_fault_code <= w_sync_code;
                  end else begin
                     r_state      <= ST_SYNC;
                     r_fault      <= 1'b0;
                     r_fault_code <= FC_NONE;
                     r_dwell      <= 4'd0;
                  end
               end
            end
            default: begin
               r_state  <= ST_SYNC;
               r_locked <= 1'b0;
            end
         endcase
      end
   end

   assign phase      = w_cur_ph;
   assign locked     = r_locked;
   assign fault      = r_fault;
   assign fault_code = r_fault_code;
   assign cycle_done = r_cycle_done;
   assign cycle_cnt  = r_cycle_cnt;

endmodule

// File: tb/tb_light_monitor.sv
// Self-checking bench for light_monitor: scenario tasks plus a phase scoreboard.
// Latency: expected phase is due one clk after the sample is driven.
// Backpressure: none.
module tb_light_monitor;

   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] A = 3'b010;
   localparam logic [2:0] G = 3'b001;
   localparam logic [11:0] P1 = {G, G, R, R};
   localparam logic [11:0] P2 = {G, A, R, R};
   localparam logic [11:0] P3 = {G, R, G, R};
   localparam logic [11:0] P4 = {A, R, A, R};
   localparam logic [11:0] P5 = {R, R, R, G};
   localparam logic [11:0] P6 = {R, R, R, A};
   localparam logic [11:0] GLITCH = {G, R, 3'b011, R};

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] m1, m2, mt, st;
   logic       clr_fault;
   logic [2:0] phase;
   logic       locked, fault, cycle_done;
   logic [1:0] fault_code;
   logic [7:0] cycle_cnt;

   int n_checks = 0;
   int n_pass   = 0;
   int n_done   = 0;
   int cyc      = 0;

   typedef struct {
      int         due;
      logic [2:0] ph;
   } sb_t;
   sb_t sb_q[$];

   always #5 clk = ~clk;

   light_monitor dut (
      .clk(clk), .rst(rst),
      .light_M1(m1), .light_M2(m2), .light_MT(mt), .light_ST(st),
      .clr_fault(clr_fault),
      .phase(phase), .locked(locked), .fault(fault), .fault_code(fault_code),
      .cycle_done(cycle_done), .cycle_cnt(cycle_cnt)
   );

   // Independent reference decode of the lamp table
   function automatic logic [2:0] exp_phase(input logic [11:0] p);
      case (p)
         {3'b001, 3'b001, 3'b100, 3'b100}: exp_phase = 3'd1;
         {3'b001, 3'b010, 3'b100, 3'b100}: exp_phase = 3'd2;
         {3'b001, 3'b100, 3'b001, 3'b100}: exp_phase = 3'd3;
         {3'b010, 3'b100, 3'b010, 3'b100}: exp_phase = 3'd4;
         {3'b100, 3'b100, 3'b100, 3'b001}: exp_phase = 3'd5;
         {3'b100, 3'b100, 3'b100, 3'b010}: exp_phase = 3'd6;
         default:                          exp_phase = 3'd0;
      endcase
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard consumer and cycle_done pulse counter, sampled on the falling edge
   always @(negedge clk) begin
      sb_t e;
      if (cycle_done === 1'b1) n_done++;
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
         e = sb_q.pop_front();
         n_checks++;
         if (phase !== e.ph) $display("FAIL phase_sb cyc=%0d got %0d want %0d", cyc, phase, e.ph);
         else n_pass++;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout reached before summary");
      $fatal(1, "timeout");
   end

   // Drive one pattern for n clks; called and returns at a falling edge.
   task automatic drive(input logic [11:0] p, input int n, input logic clr = 1'b0);
      sb_t e;
      for (int i = 0; i < n; i++) begin
         {m1, m2, mt, st} = p;
         clr_fault = clr;
         e.due = cyc + 1;
         e.ph  = exp_phase(p);
         sb_q.push_back(e);
         @(posedge clk);
         @(negedge clk);
      end
      clr_fault = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      clr_fault = 1'b0;
      {m1, m2, mt, st} = '0;
      sb_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic full_cycle();
      drive(P1, 8); drive(P2, 3); drive(P3, 6);
      drive(P4, 3); drive(P5, 4); drive(P6, 3);
   endtask

   task automatic test_reset();
      #1;
      n_checks++; if (phase !== 3'd0) $display("FAIL rst_phase got %0d want 0", phase); else n_pass++;
      n_checks++; if (locked !== 1'b0) $display("FAIL rst_locked got %0b want 0", locked); else n_pass++;
      n_checks++; if (fault !== 1'b0) $display("FAIL rst_fault got %0b want 0", fault); else n_pass++;
      n_checks++; if (fault_code !== 2'd0) $display("FAIL rst_code got %0d want 0", fault_code); else n_pass++;
      n_checks++; if (cycle_done !== 1'b0) $display("FAIL rst_done got %0b want 0", cycle_done); else n_pass++;
      n_checks++; if (cycle_cnt !== 8'd0) $display("FAIL rst_cnt got %0d want 0", cycle_cnt); else n_pass++;
      // Input registers stay cleared while reset is held
      {m1, m2, mt, st} = P1;
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (phase !== 3'd0) $display("FAIL rst_hold_phase got %0d want 0", phase); else n_pass++;
   endtask

   task automatic test_normal();
      do_reset();
      n_done = 0;
      drive(P1, 8);
      drive(P2, 1);
      n_checks++; if (locked !== 1'b0) $display("FAIL norm_sync_locked got %0b want 0", locked); else n_pass++;
      drive(P2, 1);
      n_checks++; if (locked !== 1'b1) $display("FAIL norm_lock got %0b want 1", locked); else n_pass++;
      drive(P2, 1); drive(P3, 6); drive(P4, 3); drive(P5, 4); drive(P6, 3);
      full_cycle();
      full_cycle();
      n_checks++; if (locked !== 1'b1) $display("FAIL norm_locked_end got %0b want 1", locked); else n_pass++;
      n_checks++; if (fault !== 1'b0) $display("FAIL norm_fault got %0b want 0", fault); else n_pass++;
      n_checks++; if (cycle_cnt !== 8'd2) $display("FAIL norm_cnt got %0d want 2", cycle_cnt); else n_pass++;
      n_checks++; if (n_done !== 2) $display("FAIL norm_pulses got %0d want 2", n_done); else n_pass++;
   endtask

   task automatic test_illegal();
      do_reset();
      drive(P1, 8); drive(P2, 3); drive(P3, 2);
      drive(GLITCH, 1);
      n_checks++; if (fault !== 1'b0) $display("FAIL ill_latency got %0b want 0", fault); else n_pass++;
      drive(P3, 1);
      n_checks++; if (fault !== 1'b1) $display("FAIL ill_fault got %0b want 1", fault); else n_pass++;
      n_checks++; if (fault_code !== 2'd1) $display("FAIL ill_code got %0d want 1", fault_code); else n_pass++;
      n_checks++; if (locked !== 1'b0) $display("FAIL ill_locked got %0b want 0", locked); else n_pass++;
   endtask

   // Continues from the fault latched by test_illegal
   task automatic test_clear();
      drive(P3, 1, 1'b1);
      n_checks++; if (fault !== 1'b0) $display("FAIL clr_fault got %0b want 0", fault); else n_pass++;
      n_checks++; if (fault_code !== 2'd0) $display("FAIL clr_code got %0d want 0", fault_code); else n_pass++;
      n_checks++; if (locked !== 1'b0) $display("FAIL clr_locked got %0b want 0", locked); else n_pass++;
      drive(P3, 1);
      drive(GLITCH, 2, 1'b1);
      n_checks++; if (fault !== 1'b1) $display("FAIL clr_ill_fault got %0b want 1", fault); else n_pass++;
      n_checks++; if (fault_code !== 2'd1) $display("FAIL clr_ill_code got %0d want 1", fault_code); else n_pass++;
      drive(GLITCH, 1, 1'b1);
      n_checks++; if (fault !== 1'b1) $display("FAIL clr_ignored_fault got %0b want 1", fault); else n_pass++;
      n_checks++; if (fault_code !== 2'd1) $display("FAIL clr_ignored_code got %0d want 1", fault_code); else n_pass++;
   endtask

   task automatic test_skip();
      do_reset();
      drive(P1, 8); drive(P2, 3);
      drive(P4, 1);
      n_checks++; if (fault !== 1'b0) $display("FAIL skip_latency got %0b want 0", fault); else n_pass++;
      drive(P4, 1);
      n_checks++; if (fault_code !== 2'd2) $display("FAIL skip_code got %0d want 2", fault_code); else n_pass++;
   endtask

   task automatic test_dwell();
      do_reset();
      full_cycle();
      drive(P1, 7);
      drive(P2, 1);
      n_checks++; if (fault !== 1'b0) $display("FAIL short_latency got %0b want 0", fault); else n_pass++;
      drive(P2, 1);
      n_checks++; if (fault !== 1'b1) $display("FAIL short_fault got %0b want 1", fault); else n_pass++;
      n_checks++; if (fault_code !== 2'd3) $display("FAIL short_code got %0d want 3", fault_code); else n_pass++;

      do_reset();
      drive(P1, 8); drive(P2, 3); drive(P3, 6); drive(P4, 3);
      drive(P5, 5);
      n_checks++; if (fault !== 1'b0) $display("FAIL long_latency got %0b want 0", fault); else n_pass++;
      drive(P5, 1);
      n_checks++; if (fault !== 1'b1) $display("FAIL long_fault got %0b want 1", fault); else n_pass++;
      n_checks++; if (fault_code !== 2'd3) $display("FAIL long_code got %0d want 3", fault_code); else n_pass++;
   endtask

   task automatic test_wrap_and_reset();
      do_reset();
      full_cycle();
      for (int i = 1; i <= 256; i++) begin
         drive(P1, 2);
         if (i == 255) begin
            n_checks++; if (cycle_cnt !== 8'd255) $display("FAIL wrap_255 got %0d want 255", cycle_cnt); else n_pass++;
         end
         if (i == 256) begin
            n_checks++; if (cycle_cnt !== 8'd0) $display("FAIL wrap_0 got %0d want 0", cycle_cnt); else n_pass++;
            n_checks++; if (cycle_done !== 1'b1) $display("FAIL wrap_done got %0b want 1", cycle_done); else n_pass++;
         end
         drive(P1, 6); drive(P2, 3); drive(P3, 6);
         if (i < 256) begin
            drive(P4, 3); drive(P5, 4); drive(P6, 3);
         end
      end
      // Overstay P4 to latch a dwell fault, then reset between clock edges
      drive(P4, 5);
      n_checks++; if (fault_code !== 2'd3) $display("FAIL p4_code got %0d want 3", fault_code); else n_pass++;
      #2;
      rst = 1'b0;
      #1;
      n_checks++; if (phase !== 3'd0) $display("FAIL mid_rst_phase got %0d want 0", phase); else n_pass++;
      n_checks++; if (fault !== 1'b0) $display("FAIL mid_rst_fault got %0b want 0", fault); else n_pass++;
      n_checks++; if (fault_code !== 2'd0) $display("FAIL mid_rst_code got %0d want 0", fault_code); else n_pass++;
      n_checks++; if (locked !== 1'b0) $display("FAIL mid_rst_locked got %0b want 0", locked); else n_pass++;
      n_checks++; if (cycle_cnt !== 8'd0) $display("FAIL mid_rst_cnt got %0d want 0", cycle_cnt); else n_pass++;
      n_checks++; if (cycle_done !== 1'b0) $display("FAIL mid_rst_done got %0b want 0", cycle_done); else n_pass++;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0;
      clr_fault = 1'b0;
      {m1, m2, mt, st} = '0;
      @(negedge clk);
      test_reset();
      test_normal();
      test_illegal();
      test_clear();
      test_skip();
      test_dwell();
      test_wrap_and_reset();
      n_checks++; if (sb_q.size() !== 0) $display("FAIL sb_leftover got %0d want 0", sb_q.size()); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
